brick_health_mem: RTL and testbench

- Per-brick health store that consumes the level loader's write stream (address, health, writeEn) and the loader's done/total_health outputs.
- Services ball-collision hit requests with a read-modify-write that decrements brick health.
- Tracks remaining total health and raises level_clear when every brick is destroyed.
- Also provides a registered read port so the renderer can redraw bricks.

---
 rtl/brick_health_mem.sv | 235 +++++++++++++++++++++++
 tb/tb_brick_health_mem.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/brick_health_mem.sv
// ---------------------------------------------------------------------------
// brick_health_mem
//
// Per-brick health store for one level of the brick breaker.
//
// The level loader fills the store through load_we/load_addr/load_health
// while load_complete is low. Raising load_complete freezes the level and
// captures total_health_in as the remaining health. Ball collisions arrive
// as hit requests. Each request is a read-modify-write through a small FSM:
// IDLE -> READ -> CHECK -> RESP. The FSM decrements the brick and the
// remaining total, then reports the outcome on a one-cycle hit_valid strobe.
// A second, read-only port lets the renderer redraw bricks.
//
// Ports
//   clk, resetn        clock, synchronous active-low reset
//   load_we/addr/health loader write stream (ignored while a level is held)
//   load_complete       high while the loaded level is in play
//   total_health_in     level total, captured on load_complete rising
//   hit_req/hit_addr    collision request, accepted when hit_ready
//   hit_ready           FSM idle, level loaded and not yet cleared
//   hit_valid           one-cycle response strobe
//   hit_was_brick       addressed slot held a live brick
//   hit_destroyed       the hit took the brick from 1 to 0
//   hit_new_health      brick health after the hit
//   rd_addr/rd_health   renderer read port, one cycle latency
//   remaining           remaining total health of the level
//   level_clear         level loaded and no health left
// ---------------------------------------------------------------------------

// Protocol invariants of brick_health_mem, kept apart from the datapath.
module brick_health_mem_chk (
    input logic       clk,
    input logic       resetn,
    input logic       state_idle,
    input logic       loaded,
    input logic       hit_ready,
    input logic       hit_valid,
    input logic       hit_was_brick,
    input logic       hit_destroyed,
    input logic [1:0] hit_new_health,
    input logic [9:0] remaining,
    input logic       level_clear
);
    a_valid_one_cycle: assert property (@(posedge clk) disable iff (!resetn)
        hit_valid |=> !hit_valid);

    a_ready_only_idle: assert property (@(posedge clk) disable iff (!resetn)
        hit_ready |-> state_idle);

    a_clear_blocks_hits: assert property (@(posedge clk) disable iff (!resetn)
        level_clear |-> !hit_ready);

    a_destroy_consistent: assert property (@(posedge clk) disable iff (!resetn)
        hit_destroyed |-> (hit_was_brick && (hit_new_health == 2'b00)));

    a_unloaded_empty: assert property (@(posedge clk) disable iff (!resetn)
        !loaded |-> (remaining == 10'd0));
endmodule

module brick_health_mem #(
    parameter int DEPTH  = 128,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              load_we,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [1:0]        load_health,
    input  logic              load_complete,
    input  logic [9:0]        total_health_in,
    input  logic              hit_req,
    input  logic [ADDR_W-1:0] hit_addr,
    output logic              hit_ready,
    output logic              hit_valid,
    output logic              hit_was_brick,
    output logic              hit_destroyed,
    output logic [1:0]        hit_new_health,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [1:0]        rd_health,
    output logic [9:0]        remaining,
    output logic              level_clear
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One bit wider than the address so DEPTH == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_CHECK = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    // Addresses at or above DEPTH never touch the array. Their low bits
    // would otherwise alias onto real slots.
    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
        return ({1'b0, addr} < DEPTH_LIM);
    endfunction

    state_t            state_r;
    logic              loaded_r;
    logic [ADDR_W-1:0] hit_addr_r;
    logic [1:0]        rd_data_r;
    logic [1:0]        mem_r [DEPTH];

    logic              hit_brick_s;
    logic              mem_we_s;
    logic [IDX_W-1:0]  mem_waddr_s;
    logic [1:0]        mem_wdata_s;

    assign hit_brick_s = (rd_data_r != 2'b00) && addr_in_range(hit_addr_r);
    assign hit_ready   = (state_r == S_IDLE) && loaded_r && !level_clear;
    assign level_clear = loaded_r && (remaining == 10'd0);

    // Select the single writer of the shared port. A hit write-back has
    // priority because it can only overlap a load after load_complete fell
    // mid-hit. Nothing is written while reset is asserted.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_waddr_s = '0;
        mem_wdata_s = 2'b00;
        if (!resetn) begin
            mem_we_s = 1'b0;
        end else if ((state_r == S_CHECK) && hit_brick_s) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = hit_addr_r[IDX_W-1:0];
            mem_wdata_s = rd_data_r - 2'd1;
        end else if (!loaded_r && load_we && addr_in_range(load_addr)) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = load_addr[IDX_W-1:0];
            mem_wdata_s = load_health;
        end else begin
            mem_we_s = 1'b0;
        end
    end

    // Brick health array write port (contents survive reset).
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[mem_waddr_s] <= mem_wdata_s;
        end
    end

    // Renderer read port, out-of-range addresses read as empty.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rd_health <= 2'b00;
        end else if (addr_in_range(rd_addr)) begin
            rd_health <= mem_r[rd_addr[IDX_W-1:0]];
        end else begin
            rd_health <= 2'b00;
        end
    end

    // Hit FSM with its response registers, plus level loaded/remaining tracking.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r        <= S_IDLE;
            loaded_r       <= 1'b0;
            hit_addr_r     <= '0;
            rd_data_r      <= 2'b00;
            hit_valid      <= 1'b0;
            hit_was_brick  <= 1'b0;
            hit_destroyed  <= 1'b0;
            hit_new_health <= 2'b00;
            remaining      <= 10'd0;
        end else begin
            hit_valid <= 1'b0;

            case (state_r)
                S_IDLE: begin
                    if (hit_req && hit_ready) begin
                        hit_addr_r <= hit_addr;
                        state_r    <= S_READ;
                    end else begin
                        state_r    <= S_IDLE;
                    end
                end
                S_READ: begin
                    rd_data_r <= mem_r[hit_addr_r[IDX_W-1:0]];
                    state_r   <= S_CHECK;
                end
                S_CHECK: begin
                    if (hit_brick_s) begin
                        hit_was_brick  <= 1'b1;
                        hit_new_health <= rd_data_r - 2'd1;
                        hit_destroyed  <= (rd_data_r == 2'd1);
                    end else begin
                        hit_was_brick  <= 1'b0;
                        hit_new_health <= 2'b00;
                        hit_destroyed  <= 1'b0;
                    end
                    state_r <= S_RESP;
                end
                S_RESP: begin
                    // The strobe is registered, so it shows in the idle cycle
                    // after S_RESP.
                    hit_valid <= 1'b1;
                    state_r   <= S_IDLE;
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase

            // loaded_r doubles as the delayed copy of load_complete. A level
            // edge overrides a concurrent decrement from an in-flight hit.
            if (load_complete && !loaded_r) begin
                loaded_r  <= 1'b1;
                remaining <= total_health_in;
            end else if (!load_complete && loaded_r) begin
                loaded_r  <= 1'b0;
                remaining <= 10'd0;
            end else if ((state_r == S_CHECK) && hit_brick_s && (remaining != 10'd0)) begin
                remaining <= remaining - 10'd1;
            end else begin
                remaining <= remaining;
            end
        end
    end

    brick_health_mem_chk u_chk (
        .clk            (clk),
        .resetn         (resetn),
        .state_idle     (state_r == S_IDLE),
        .loaded         (loaded_r),
        .hit_ready      (hit_ready),
        .hit_valid      (hit_valid),
        .hit_was_brick  (hit_was_brick),
        .hit_destroyed  (hit_destroyed),
        .hit_new_health (hit_new_health),
        .remaining      (remaining),
        .level_clear    (level_clear)
    );
endmodule

// File: tb/tb_brick_health_mem.sv
// ---------------------------------------------------------------------------
// tb_brick_health_mem
//
// Self-checking bench for brick_health_mem. It has three parts:
// - tables of hand-derived hit and read vectors for one fixed level;
// - hand-written sequences for reset, mid-hit level drop and reset-mid-hit;
// - randomized levels and hits checked against a transaction-level model
//   (an array of brick healths plus a remaining counter).
// ---------------------------------------------------------------------------
module tb_brick_health_mem;
    localparam int DEPTH  = 128;
    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              load_we = 1'b0;
    logic [ADDR_W-1:0] load_addr = '0;
    logic [1:0]        load_health = 2'b00;
    logic              load_complete = 1'b0;
    logic [9:0]        total_health_in = 10'd0;
    logic              hit_req = 1'b0;
    logic [ADDR_W-1:0] hit_addr = '0;
    logic              hit_ready;
    logic              hit_valid;
    logic              hit_was_brick;
    logic              hit_destroyed;
    logic [1:0]        hit_new_health;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic [1:0]        rd_health;
    logic [9:0]        remaining;
    logic              level_clear;

    brick_health_mem #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .load_we         (load_we),
        .load_addr       (load_addr),
        .load_health     (load_health),
        .load_complete   (load_complete),
        .total_health_in (total_health_in),
        .hit_req         (hit_req),
        .hit_addr        (hit_addr),
        .hit_ready       (hit_ready),
        .hit_valid       (hit_valid),
        .hit_was_brick   (hit_was_brick),
        .hit_destroyed   (hit_destroyed),
        .hit_new_health  (hit_new_health),
        .rd_addr         (rd_addr),
        .rd_health       (rd_health),
        .remaining       (remaining),
        .level_clear     (level_clear)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: brick healths and level state as plain numbers.
    int mmem[DEPTH];
    int mrem = 0;
    bit mloaded = 1'b0;
    int lvl[DEPTH];

    typedef struct {
        int addr;
        bit was;
        bit dest;
        int nh;
        int rem;
    } hit_vec_t;

    typedef struct {
        int addr;
        int exp;
    } rd_vec_t;

    hit_vec_t hit_tab[10];
    rd_vec_t  rd_pre[5];
    rd_vec_t  rd_post[6];

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_hit(input int a, output bit was, output bit dest, output int nh);
        if (a < DEPTH && mmem[a] != 0) begin
            nh      = mmem[a] - 1;
            dest    = (mmem[a] == 1);
            was     = 1'b1;
            mmem[a] = nh;
            if (mrem > 0) mrem--;
        end else begin
            was = 1'b0; dest = 1'b0; nh = 0;
        end
    endtask

    // Issue one hit and wait (bounded) for its response. lat counts clock
    // edges after the accepting edge; 99 means no response arrived.
    task automatic do_hit(input int a, output int lat, output bit was, output bit dest,
                          output int nh, output bit vafter);
        hit_addr = ADDR_W'(a);
        hit_req  = 1'b1;
        tick();
        hit_req  = 1'b0;
        lat = 99;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (hit_valid) begin
                lat = c;
                break;
            end
        end
        was  = hit_was_brick;
        dest = hit_destroyed;
        nh   = int'(hit_new_health);
        tick();
        vafter = hit_valid;
    endtask

    task automatic read_check(input string name, input int a, input int exp);
        rd_addr = ADDR_W'(a);
        tick();
        check(name, int'(rd_health), exp);
    endtask

    // Drop load_complete, write every slot from lvl[], try a few out-of-range
    // writes that alias real slots, then raise load_complete with total.
    task automatic load_level(input int total);
        load_complete = 1'b0;
        tick();
        mloaded = 1'b0; mrem = 0;
        load_we = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            load_addr   = ADDR_W'(i);
            load_health = 2'(lvl[i]);
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            load_addr   = ADDR_W'(DEPTH + 17 + 3 * i);
            load_health = 2'd3;
            tick();
        end
        load_we = 1'b0;
        for (int i = 0; i < DEPTH; i++) mmem[i] = lvl[i];
        total_health_in = 10'(total);
        load_complete   = 1'b1;
        tick();
        mloaded = 1'b1; mrem = total;
        check("load_remaining", int'(remaining), total);
        check("load_hit_ready", int'(hit_ready), (total != 0) ? 1 : 0);
        check("load_level_clear", int'(level_clear), (total == 0) ? 1 : 0);
    endtask

    int  lat, nh, enh, a, ra, sum, nvalid;
    bit  was, dest, vafter, ewas, edest;

    initial begin
        hit_tab[0] = '{18,  1'b1, 1'b0, 1, 30};
        hit_tab[1] = '{18,  1'b1, 1'b1, 0, 29};
        hit_tab[2] = '{5,   1'b0, 1'b0, 0, 29};
        hit_tab[3] = '{200, 1'b0, 1'b0, 0, 29};
        hit_tab[4] = '{18,  1'b0, 1'b0, 0, 29};
        hit_tab[5] = '{19,  1'b1, 1'b0, 2, 28};
        hit_tab[6] = '{49,  1'b1, 1'b1, 0, 27};
        hit_tab[7] = '{127, 1'b0, 1'b0, 0, 27};
        hit_tab[8] = '{145, 1'b0, 1'b0, 0, 27};
        hit_tab[9] = '{17,  1'b1, 1'b1, 0, 26};

        rd_pre[0] = '{19, 3};
        rd_pre[1] = '{0, 0};
        rd_pre[2] = '{20, 1};
        rd_pre[3] = '{150, 0};
        rd_pre[4] = '{49, 1};

        rd_post[0] = '{18, 0};
        rd_post[1] = '{19, 2};
        rd_post[2] = '{17, 0};
        rd_post[3] = '{49, 0};
        rd_post[4] = '{20, 1};
        rd_post[5] = '{148, 0};

        // Reset state.
        rd_addr = ADDR_W'(17);
        tick(); tick();
        check("rst_hit_valid", int'(hit_valid), 0);
        check("rst_rd_health", int'(rd_health), 0);
        check("rst_remaining", int'(remaining), 0);
        check("rst_hit_ready", int'(hit_ready), 0);
        check("rst_level_clear", int'(level_clear), 0);
        resetn = 1'b1;
        tick();
        check("post_rst_hit_ready", int'(hit_ready), 0);
        check("post_rst_level_clear", int'(level_clear), 0);

        // Level one: 17..31 healths 1,2,3 repeating, 49=1, total 31.
        for (int i = 0; i < DEPTH; i++) lvl[i] = 0;
        for (int i = 17; i <= 31; i++) lvl[i] = ((i - 17) % 3) + 1;
        lvl[49] = 1;
        load_level(31);

        // A loader write while the level is held must be ignored.
        load_we = 1'b1; load_addr = ADDR_W'(20); load_health = 2'd3;
        tick();
        load_we = 1'b0;

        for (int i = 0; i < 5; i++) read_check("rd_pre", rd_pre[i].addr, rd_pre[i].exp);

        for (int i = 0; i < 10; i++) begin
            do_hit(hit_tab[i].addr, lat, was, dest, nh, vafter);
            model_hit(hit_tab[i].addr, ewas, edest, enh);
            check("tab_latency", lat, 3);
            check("tab_was_brick", int'(was), int'(hit_tab[i].was));
            check("tab_destroyed", int'(dest), int'(hit_tab[i].dest));
            check("tab_new_health", nh, hit_tab[i].nh);
            check("tab_remaining", int'(remaining), hit_tab[i].rem);
            check("tab_valid_one_cycle", int'(vafter), 0);
        end

        for (int i = 0; i < 6; i++) read_check("rd_post", rd_post[i].addr, rd_post[i].exp);

        // Knock every remaining brick down to zero.
        for (int i = 0; i < DEPTH; i++) begin
            while (mmem[i] != 0) begin
                do_hit(i, lat, was, dest, nh, vafter);
                model_hit(i, ewas, edest, enh);
                check("clr_latency", lat, 3);
                check("clr_was_brick", int'(was), int'(ewas));
                check("clr_destroyed", int'(dest), int'(edest));
                check("clr_new_health", nh, enh);
                check("clr_remaining", int'(remaining), mrem);
            end
        end
        check("clr_final_remaining", int'(remaining), 0);
        check("clr_level_clear", int'(level_clear), 1);
        check("clr_hit_ready", int'(hit_ready), 0);
        nvalid = 0;
        hit_addr = ADDR_W'(19);
        hit_req  = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (hit_valid) nvalid++;
        end
        hit_req = 1'b0;
        check("clr_ignored_hits", nvalid, 0);

        // load_complete falls while a hit is in flight.
        for (int i = 0; i < DEPTH; i++) lvl[i] = 0;
        lvl[30] = 2; lvl[20] = 2; lvl[5] = 1;
        load_level(5);
        hit_addr = ADDR_W'(30); hit_req = 1'b1;
        tick();
        hit_req = 1'b0; load_complete = 1'b0;
        tick();
        check("drop_remaining", int'(remaining), 0);
        check("drop_hit_ready", int'(hit_ready), 0);
        tick();
        tick();
        check("drop_hit_valid", int'(hit_valid), 1);
        check("drop_was_brick", int'(hit_was_brick), 1);
        check("drop_new_health", int'(hit_new_health), 1);
        check("drop_remaining_after", int'(remaining), 0);
        check("drop_level_clear", int'(level_clear), 0);
        read_check("drop_writeback", 30, 1);
        mmem[30] = 1;

        // Reset while a hit on 20 sits in S_CHECK.
        total_health_in = 10'd4; load_complete = 1'b1;
        tick();
        check("relatch_remaining", int'(remaining), 4);
        hit_addr = ADDR_W'(20); hit_req = 1'b1;
        tick();
        hit_req = 1'b0;
        tick();
        resetn = 1'b0; load_complete = 1'b0;
        tick();
        check("mid_rst_hit_valid", int'(hit_valid), 0);
        check("mid_rst_remaining", int'(remaining), 0);
        check("mid_rst_hit_ready", int'(hit_ready), 0);
        check("mid_rst_level_clear", int'(level_clear), 0);
        tick();
        resetn = 1'b1;
        nvalid = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (hit_valid) nvalid++;
        end
        check("mid_rst_no_response", nvalid, 0);
        read_check("mid_rst_no_writeback", 20, 2);
        for (int i = 0; i < DEPTH; i++) lvl[i] = 0;
        lvl[20] = 3; lvl[7] = 2;
        load_level(5);
        read_check("reload_addr20", 20, 3);

        // Empty level is clear immediately.
        for (int i = 0; i < DEPTH; i++) lvl[i] = 0;
        load_level(0);

        // Randomized levels and hits against the model.
        for (int lv = 0; lv < 3; lv++) begin
            sum = 0;
            for (int i = 0; i < DEPTH; i++) begin
                lvl[i] = (i < 48) ? int'($urandom_range(0, 3)) : 0;
                sum += lvl[i];
            end
            load_level(sum);
            for (int n = 0; n < 30; n++) begin
                if (!(mloaded && mrem != 0)) break;
                a = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 1023))
                                                : int'($urandom_range(0, 63));
                do_hit(a, lat, was, dest, nh, vafter);
                model_hit(a, ewas, edest, enh);
                check("rnd_latency", lat, 3);
                check("rnd_was_brick", int'(was), int'(ewas));
                check("rnd_destroyed", int'(dest), int'(edest));
                check("rnd_new_health", nh, enh);
                check("rnd_remaining", int'(remaining), mrem);
                check("rnd_level_clear", int'(level_clear), (mrem == 0) ? 1 : 0);
                ra = int'($urandom_range(0, 255));
                read_check("rnd_read", ra, (ra < DEPTH) ? mmem[ra] : 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
